// File: rtl/load_store_unit.sv
// load_store_unit
// CPU-side initiator for a single-port synchronous data memory with a
// one-cycle registered read. It takes one load/store at a time from the
// pipeline, turns the byte address into a word address and drives the
// memory port. Sub-word stores are done as read-modify-write. Loads return
// sign/zero-extended data with a one-cycle response pulse.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we                1 = store, 0 = load
//   req_funct             000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU load only)
//   req_addr              byte address (ADDR_WIDTH+2 bits)
//   req_wdata             store data, sub-word data taken from the low bits
//   rsp_valid             one-cycle completion pulse
//   rsp_data              load result, 0 for stores and errors
//   rsp_err               misaligned address or illegal funct
//   mem_addr/mem_din      registered word address and write data
//   mem_wr_rd             registered write strobe (1 = write, 0 = read)
//   mem_dout              memory read data, valid the cycle after a read edge
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wr_rd,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    CAPTURE,
    WRITE,
    ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;
  logic                    mem_wr_rd_q, mem_wr_rd_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [2:0]              funct_q, funct_d;
  logic [1:0]              lane_q, lane_d;
  logic [15:0]             wdata_q, wdata_d;
  logic                    isStore_q, isStore_d;
  // Goes high on the first edge after reset so a request held during reset
  // is not accepted before the block has seen a clean clock.
  logic                    active_q;

  logic                    reqLegal;
  logic                    reqMisaligned;
  logic [7:0]              selByte;
  logic [15:0]             selHalf;
  logic [DATA_WIDTH-1:0]   loadData;
  logic [DATA_WIDTH-1:0]   mergedWord;

  assign req_ready = (state_q == IDLE) && active_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wr_rd = mem_wr_rd_q;

  // Request decode: unsigned variants exist only for loads; word accesses
  // need a 4-byte aligned address, halfword accesses a 2-byte aligned one.
  always_comb begin
    reqLegal      = 1'b0;
    reqMisaligned = 1'b0;
    case (req_funct)
      F_B, F_H, F_W: reqLegal = 1'b1;
      F_BU, F_HU:    reqLegal = !req_we;
      default:       reqLegal = 1'b0;
    endcase
    if (req_funct[1:0] == 2'b10) begin
      reqMisaligned = (req_addr[1:0] != 2'b00);
    end else if (req_funct[1:0] == 2'b01) begin
      reqMisaligned = req_addr[0];
    end
  end

  // Lane extraction and lane merge on the word read back from memory.
  // Lanes are little-endian: lane 0 is bits 7:0, half 1 is bits 31:16.
  always_comb begin
    selByte    = mem_dout[{lane_q, 3'b000} +: 8];
    selHalf    = mem_dout[{lane_q[1], 4'b0000} +: 16];
    mergedWord = mem_dout;
    if (funct_q == F_H) begin
      mergedWord[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      mergedWord[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
    case (funct_q)
      F_B:     loadData = {{(DATA_WIDTH-8){selByte[7]}}, selByte};
      F_H:     loadData = {{(DATA_WIDTH-16){selHalf[15]}}, selHalf};
      F_BU:    loadData = {{(DATA_WIDTH-8){1'b0}}, selByte};
      F_HU:    loadData = {{(DATA_WIDTH-16){1'b0}}, selHalf};
      default: loadData = mem_dout;
    endcase
  end

  // Next-state and next-output logic. The write strobe and the response
  // fields default to 0 so every pulse lasts exactly one cycle; address and
  // write data hold their last value.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_wr_rd_d = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    funct_d     = funct_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    isStore_d   = isStore_q;

    case (state_q)
      IDLE: begin
        if (req_valid && active_q) begin
          if (!reqLegal || reqMisaligned) begin
            // The error response is raised straight away so it appears one
            // cycle after acceptance; ERROR just lets it drop again.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = ERROR;
          end else begin
            mem_addr_d = req_addr[ADDR_WIDTH+1:2];
            funct_d    = req_funct;
            lane_d     = req_addr[1:0];
            wdata_d    = req_wdata[15:0];
            isStore_d  = req_we;
            if (req_we && (req_funct == F_W)) begin
              mem_din_d   = req_wdata;
              mem_wr_rd_d = 1'b1;
            end
            state_d = ACCESS;
          end
        end
      end

      ERROR: begin
        state_d = IDLE;
      end

      ACCESS: begin
        if (isStore_q && (funct_q == F_W)) begin
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        if (isStore_q) begin
          mem_din_d   = mergedWord;
          mem_wr_rd_d = 1'b1;
          state_d     = WRITE;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = loadData;
          state_d     = IDLE;
        end
      end

      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything, which also drops
  // any pending read-modify-write before its write edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_wr_rd_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      funct_q     <= '0;
      lane_q      <= '0;
      wdata_q     <= '0;
      isStore_q   <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_wr_rd_q <= mem_wr_rd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      funct_q     <= funct_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      isStore_q   <= isStore_d;
      active_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a behavioural synchronous memory with a
// registered read port sits behind the DUT, and a word-level reference model
// predicts load data, error flags, response latency and write counts.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [10:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_wr_rd;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;
  int writeCount = 0;
  int cyc = 0;

  logic [31:0] memArr [0:2047];
  logic [31:0] refMem [0:15];

  logic [10:0] obsAddr;
  logic        obsWr;
  int          acceptCyc;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct (req_funct),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_wr_rd (mem_wr_rd),
    .mem_dout  (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: write on WR_RD, registered read data every edge.
  always @(posedge clk) begin
    if (mem_wr_rd === 1'b1) begin
      memArr[mem_addr] <= mem_din;
      writeCount <= writeCount + 1;
    end
    mem_dout <= memArr[mem_addr];
    cyc <= cyc + 1;
  end

  // Reference arithmetic on whole words.
  function automatic logic [31:0] refLoad(input logic [31:0] w, input int f, input int lane);
    logic [31:0] b, h;
    b = (w >> (lane * 8)) & 32'hFF;
    h = (w >> ((lane / 2) * 16)) & 32'hFFFF;
    case (f)
      0: refLoad = (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      1: refLoad = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      4: refLoad = b;
      5: refLoad = h;
      default: refLoad = w;
    endcase
  endfunction

  function automatic logic [31:0] refStore(input logic [31:0] w, input int f, input int lane,
                                           input logic [31:0] wd);
    logic [31:0] mask;
    if (f == 2) return wd;
    if (f == 0) begin
      mask = 32'hFF << (lane * 8);
      return (w & ~mask) | ((wd & 32'hFF) << (lane * 8));
    end
    mask = 32'hFFFF << ((lane / 2) * 16);
    return (w & ~mask) | ((wd & 32'hFFFF) << ((lane / 2) * 16));
  endfunction

  // Drives one request starting at a negedge and returns at the negedge on
  // which rsp_valid is seen; latency counts cycles from the acceptance edge.
  task automatic applyStimulus(input logic we, input logic [2:0] f, input logic [12:0] a,
                               input logic [31:0] wd, output logic [31:0] data,
                               output logic err, output int lat);
    int guard;
    req_valid = 1'b1;
    req_we    = we;
    req_funct = f;
    req_addr  = a;
    req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: req_ready=%b required 1", req_ready);
    end
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    req_valid = 1'b0;
    req_we    = $urandom_range(0, 1);
    req_funct = 3'($urandom_range(0, 7));
    req_addr  = 13'($urandom);
    req_wdata = $urandom;
    lat  = 0;
    data = '0;
    err  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        obsAddr = mem_addr;
        obsWr   = mem_wr_rd;
      end
      if (rsp_valid) begin
        lat  = k;
        data = rsp_data;
        err  = rsp_err;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid=%b required 1 within 8 cycles", rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_funct = 3'b010;
    req_addr  = 13'h010;
    req_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_ready: got %b required 0", req_ready);
      end
      checks++;
      if (mem_wr_rd !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: wr_rd=%b rsp_valid=%b required 0 0", mem_wr_rd, rsp_valid);
      end
    end
    checks++;
    if (mem_addr !== 11'h0 || mem_din !== 32'h0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: addr=%h din=%h data=%h err=%b required zeros",
               mem_addr, mem_din, rsp_data, rsp_err);
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || mem_wr_rd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_release: ready=%b wr_rd=%b required 1 0", req_ready, mem_wr_rd);
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] d;
    logic        e;
    int          lat, w0;
    w0 = writeCount;
    applyStimulus(1'b1, 3'b010, 13'h010, 32'h12345678, d, e, lat);
    checks++;
    if (obsAddr !== 11'h004 || obsWr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sw_port: addr=%h wr_rd=%b required 004 1", obsAddr, obsWr);
    end
    checks++;
    if (lat != 2 || e !== 1'b0 || d !== 32'h0 || writeCount - w0 != 1) begin
      errors++;
      $display("[TB] FAIL sw_rsp: lat=%0d err=%b data=%h writes=%0d required 2 0 0 1",
               lat, e, d, writeCount - w0);
    end
    applyStimulus(1'b0, 3'b010, 13'h010, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'h12345678 || lat != 3 || e !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lw_rsp: data=%h lat=%0d err=%b required 12345678 3 0", d, lat, e);
    end
  endtask

  task automatic test_subword_loads();
    logic [2:0]  fTab [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [12:0] aTab [4] = '{13'h023, 13'h023, 13'h022, 13'h020};
    logic [31:0] xTab [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01};
    logic [31:0] d;
    logic        e;
    int          lat;
    applyStimulus(1'b1, 3'b010, 13'h020, 32'h80FF7F01, d, e, lat);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, fTab[i], aTab[i], 32'h0, d, e, lat);
      checks++;
      if (d !== xTab[i] || lat != 3 || e !== 1'b0) begin
        errors++;
        $display("[TB] FAIL subword_load%0d: data=%h lat=%0d err=%b required %h 3 0",
                 i, d, lat, e, xTab[i]);
      end
    end
  endtask

  task automatic test_rmw();
    logic [31:0] d;
    logic        e;
    int          lat, w0;
    applyStimulus(1'b1, 3'b010, 13'h040, 32'hAABBCCDD, d, e, lat);
    w0 = writeCount;
    applyStimulus(1'b1, 3'b000, 13'h041, 32'hFFFFFF11, d, e, lat);
    checks++;
    if (lat != 4 || e !== 1'b0 || d !== 32'h0 || writeCount - w0 != 1) begin
      errors++;
      $display("[TB] FAIL sb_rsp: lat=%0d err=%b data=%h writes=%0d required 4 0 0 1",
               lat, e, d, writeCount - w0);
    end
    w0 = writeCount;
    applyStimulus(1'b1, 3'b001, 13'h042, 32'h55552233, d, e, lat);
    checks++;
    if (lat != 4 || e !== 1'b0 || writeCount - w0 != 1) begin
      errors++;
      $display("[TB] FAIL sh_rsp: lat=%0d err=%b writes=%0d required 4 0 1", lat, e, writeCount - w0);
    end
    applyStimulus(1'b0, 3'b010, 13'h040, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'h223311DD) begin
      errors++;
      $display("[TB] FAIL rmw_result: got %h required 223311DD", d);
    end
  endtask

  task automatic test_errors();
    logic        weTab [3] = '{1'b0, 1'b0, 1'b1};
    logic [2:0]  fTab  [3] = '{3'b010, 3'b001, 3'b100};
    logic [12:0] aTab  [3] = '{13'h002, 13'h001, 13'h030};
    logic [31:0] d;
    logic        e;
    int          lat, w0;
    for (int i = 0; i < 3; i++) begin
      w0 = writeCount;
      applyStimulus(weTab[i], fTab[i], aTab[i], 32'hFFFFFFFF, d, e, lat);
      checks++;
      if (e !== 1'b1 || d !== 32'h0 || lat != 1 || writeCount - w0 != 0 || obsWr !== 1'b0) begin
        errors++;
        $display("[TB] FAIL error_case%0d: err=%b data=%h lat=%0d writes=%0d required 1 0 1 0",
                 i, e, d, lat, writeCount - w0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        e;
    int          lat, rspCyc;
    applyStimulus(1'b1, 3'b010, 13'h060, 32'h0BADF00D, d, e, lat);
    rspCyc = cyc;
    applyStimulus(1'b0, 3'b010, 13'h060, 32'h0, d, e, lat);
    checks++;
    if (acceptCyc != rspCyc + 1 || d !== 32'h0BADF00D) begin
      errors++;
      $display("[TB] FAIL back_to_back: accept_cycle=%0d data=%h required %0d 0badf00d",
               acceptCyc, d, rspCyc + 1);
    end
    rspCyc = cyc;
    applyStimulus(1'b0, 3'b001, 13'h063, 32'h0, d, e, lat);
    checks++;
    if (acceptCyc != rspCyc + 1 || e !== 1'b1 || lat != 1) begin
      errors++;
      $display("[TB] FAIL back_to_back_err: accept_cycle=%0d err=%b lat=%0d required %0d 1 1",
               acceptCyc, e, lat, rspCyc + 1);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rsp_pulse_width: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] d;
    logic        e;
    int          lat, w0, seen;
    applyStimulus(1'b1, 3'b010, 13'h080, 32'hCAFEBABE, d, e, lat);
    w0 = writeCount;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_funct = 3'b000;
    req_addr  = 13'h081;
    req_wdata = 32'h00000055;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_wr_rd !== 1'b0) seen++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (seen != 0 || writeCount != w0) begin
      errors++;
      $display("[TB] FAIL mid_rmw_abort: activity=%0d writes=%0d required 0 0", seen, writeCount - w0);
    end
    applyStimulus(1'b0, 3'b010, 13'h080, 32'h0, d, e, lat);
    checks++;
    if (d !== 32'hCAFEBABE) begin
      errors++;
      $display("[TB] FAIL mid_rmw_data: got %h required cafebabe", d);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, wd, expD;
    logic        e, we, expE;
    logic [12:0] a;
    int          lat, w0, f, idx, lane, expLat, expW;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      refMem[i] = wd;
      applyStimulus(1'b1, 3'b010, 13'(13'h400 + i * 4), wd, d, e, lat);
    end
    for (int n = 0; n < 80; n++) begin
      we   = 1'($urandom_range(0, 1));
      f    = $urandom_range(0, 7);
      idx  = $urandom_range(0, 15);
      lane = $urandom_range(0, 3);
      wd   = $urandom;
      a    = 13'(13'h400 + idx * 4 + lane);
      expE = (f == 3) || (f >= 6) || (we && f >= 4) ||
             ((f == 2) && lane != 0) || ((f == 1 || f == 5) && (lane % 2) != 0);
      expD = 32'h0;
      expW = 0;
      if (expE) begin
        expLat = 1;
      end else if (we) begin
        expLat = (f == 2) ? 2 : 4;
        expW   = 1;
        refMem[idx] = refStore(refMem[idx], f, lane, wd);
      end else begin
        expLat = 3;
        expD   = refLoad(refMem[idx], f, lane);
      end
      w0 = writeCount;
      applyStimulus(we, 3'(f), a, wd, d, e, lat);
      checks++;
      if (e !== expE || d !== expD || lat != expLat || writeCount - w0 != expW) begin
        errors++;
        $display("[TB] FAIL random%0d we=%b f=%0d a=%h: err=%b data=%h lat=%0d writes=%0d required %b %h %0d %0d",
                 n, we, f, a, e, d, lat, writeCount - w0, expE, expD, expLat, expW);
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_sw_lw();
    test_subword_loads();
    test_rmw();
    test_errors();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
